mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory responder at the far end of the control unit's memory enables.
- Serves lw (opcode 000, readMem_en) and sw (opcode 001, writeMem_en) issued by the datapath.
- Each access takes a fixed number of wait states. While an access is in flight, it holds the core with stall.
- Storage is a single-port synchronous byte array inside the block.

Parameters:
- DATA_W, 8: data word width.
- ADDR_W, 8: byte address width.
- DEPTH, 256: number of words; must be ≤ 2^ADDR_W.
- WAIT_CYC, 2: wait states per access (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- readMem_en  in  1  load request from control (lw).
- writeMem_en  in  1  store request from control (sw).
- addr  in  ADDR_W  access address, held by the stalled core.
- wdata  in  DATA_W  store data, held by the stalled core.
- rdata  out  DATA_W  load data, valid when rdata_valid=1.
- rdata_valid  out  1  one-cycle pulse marking load completion.
- stall  out  1  core must freeze PC and operands while high.
- err  out  1  one-cycle pulse: illegal simultaneous read and write.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, rdata=0, rdata_valid=0, stall=0, err=0, wait counter=0. Array contents are NOT reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request: outputs idle.
- IDLE, exactly one enable at cycle T:
  - stall=1 combinationally in cycle T.
  - Latch op, addr, wdata; cnt=WAIT_CYC-1; go to WAIT.
- WAIT:
  - stall=1.
  - cnt decrements each cycle. At cnt==0 → DONE.
  - On the cnt==0 edge, a store commits to the array or a load is captured into rdata.
- DONE:
  - stall=0.
  - rdata_valid=1 for loads only.
  - Always → IDLE next cycle.
  - Enables seen in DONE belong to the finishing instruction and are ignored.
- Latency: request at T → DONE at T+WAIT_CYC+1. Default is DONE at T+3; stall is high for T..T+2.
- rdata holds its last load value until the next load completes.
- Both enables high in IDLE:
  - No access, no stall.
  - err=1 for one cycle; stay IDLE.
- Enable changes while in WAIT: ignored. The latched request completes unchanged.
- addr ≥ DEPTH: address wraps modulo DEPTH (low bits only).
- Reset mid-access: abort immediately. A pending store must not reach the array.

Optional Feature:
- Macro MEM_LAST_READ_BUF_EN.
- Defined: one-entry buffer holding {valid, addr, data} of the most recent load or store.
  - An IDLE load whose addr matches a valid entry completes in the same cycle: rdata_valid=1, stall=0, rdata comes from the buffer, state stays IDLE.
  - Every completed load or store refreshes the buffer.
  - Reset clears valid.
- Undefined: no buffer. Every load takes the full WAIT_CYC+1 latency.

Decomposition:
- Shared package isa_pkg:
  - opcode enum (LW=3'b000, SW=3'b001, BNEZ=3'b010, XOR=3'b011, INC=3'b100, SHL=3'b101, SHR=3'b110, AND=3'b111).
  - DATA_W and ADDR_W constants.
  - mem_state_t enum {IDLE, WAIT, DONE}.
- Sub-module mem_array: single-port sync-write/sync-read storage with DEPTH words. The responder FSM stays in mem_responder.

Test Plan:
- Store then load:
  - sw addr=0x10, wdata=0xA5 at T → stall high T..T+2, no rdata_valid.
  - lw addr=0x10 → rdata_valid and rdata=0xA5 at T'+3.
- Both enables high in IDLE, addr=0x20 → err pulse for 1 cycle, stall=0. A following lw 0x20 returns the prior contents, unchanged.
- Mid-access stimulus changes: start sw 0x30 = 0x11, then in WAIT change addr to 0x31 and wdata to 0xFF → 0x30 holds 0x11 and 0x31 is unchanged.
- Reset mid-write: rst_n low during WAIT of sw 0x40 = 0x77 → outputs return to reset values at once; a later lw 0x40 does not return 0x77 (pre-load 0x00 first).
- Wrap-around: DEPTH=128, sw 0x85 = 0x3C → lw 0x05 returns 0x3C.
- With MEM_LAST_READ_BUF_EN:
  - lw 0x50 twice back-to-back → second completes same cycle with stall=0.
  - sw 0x50 = 0x99 then lw 0x50 → buffer hit returns 0x99.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encoding, datapath widths and the data-memory
// responder state type.
package isa_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        LW   = 3'b000,
        SW   = 3'b001,
        BNEZ = 3'b010,
        XOR  = 3'b011,
        INC  = 3'b100,
        SHL  = 3'b101,
        SHR  = 3'b110,
        AND  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, synchronous registered read.
// Contents are never reset.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[idx] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: serves lw/sw with fixed wait states, stalling the core.
// Optional last-access buffer for zero-wait load hits: define MEM_LAST_READ_BUF_EN.
module mem_responder #(
    parameter int DATA_W   = isa_pkg::DATA_W,
    parameter int ADDR_W   = isa_pkg::ADDR_W,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              readMem_en,
    input  logic              writeMem_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              err
);
    import isa_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    mem_state_t        state, stateNext;
    opcode_t           opQ;
    logic [IDX_W-1:0]  idxIn, idxQ;
    logic [DATA_W-1:0] wdataQ, rdataQ, arrRd;
    logic [CNT_W-1:0]  cnt;
    logic              loadReq, storeReq, bothReq, bufHit, accept, lastWait;

    assign loadReq  = readMem_en & ~writeMem_en;
    assign storeReq = writeMem_en & ~readMem_en;
    assign bothReq  = readMem_en & writeMem_en;
    // Out-of-range addresses wrap onto the array
    assign idxIn    = IDX_W'({1'b0, addr} % (ADDR_W + 1)'(DEPTH));
    assign accept   = (state == IDLE) & (loadReq | storeReq) & ~bufHit;
    assign lastWait = (state == WAIT) && (cnt == '0);

`ifdef MEM_LAST_READ_BUF_EN
    logic              bufValid;
    logic [IDX_W-1:0]  bufIdx;
    logic [DATA_W-1:0] bufData;

    assign bufHit = (state == IDLE) & loadReq & bufValid & (bufIdx == idxIn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufValid <= 1'b0;
            bufIdx   <= '0;
            bufData  <= '0;
        end else if (state == DONE) begin
            bufValid <= 1'b1;
            bufIdx   <= idxQ;
            bufData  <= (opQ == SW) ? wdataQ : arrRd;
        end
    end
`else
    assign bufHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            opQ    <= LW;
            idxQ   <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opQ    <= readMem_en ? LW : SW;
                idxQ   <= idxIn;
                wdataQ <= wdata;
                cnt    <= CNT_W'(WAIT_CYC - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == DONE) && (opQ == LW)) begin
                rdataQ <= arrRd;
            end
`ifdef MEM_LAST_READ_BUF_EN
            if (bufHit) begin
                rdataQ <= bufData;
            end
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        stall       = 1'b0;
        err         = 1'b0;
        rdata_valid = 1'b0;
        rdata       = rdataQ;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    stateNext = WAIT;
                end
                err = bothReq;
`ifdef MEM_LAST_READ_BUF_EN
                if (bufHit) begin
                    rdata_valid = 1'b1;
                    rdata       = bufData;
                end
`endif
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // Enables seen here belong to the finishing instruction
                stateNext = IDLE;
                if (opQ == LW) begin
                    rdata_valid = 1'b1;
                    rdata       = arrRd;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) uArray (
        .clk    (clk),
        .wrEn   (lastWait & (opQ == SW)),
        .rdEn   (lastWait & (opQ == LW)),
        .idx    (idxQ),
        .wrData (wdataQ),
        .rdData (arrRd)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand sequences for mid-access
// and reset corner cases, then random traffic against a behavioural model.
module tb_mem_responder;

    localparam int DEPTH    = 128;
    localparam int WAIT_CYC = 2;
`ifdef MEM_LAST_READ_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       readMem_en = 1'b0;
    logic       writeMem_en = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rdata_valid, stall, err;

    mem_responder #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .DEPTH    (DEPTH),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .readMem_en  (readMem_en),
        .writeMem_en (writeMem_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: memory image, last-access buffer, last load value
    logic [7:0] mem [DEPTH];
    bit         bufValid = 1'b0;
    int         bufIdx = 0;
    logic [7:0] bufData = '0;
    logic [7:0] lastRd = '0;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] expRd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic driveIgnored(input bit perturb);
        if (perturb) begin
            readMem_en  = 1'($urandom_range(0, 1));
            writeMem_en = 1'($urandom_range(0, 1));
            addr        = 8'($urandom);
            wdata       = 8'($urandom);
        end else begin
            readMem_en  = 1'b0;
            writeMem_en = 1'b0;
        end
    endtask

    task automatic runOp(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input bit perturb, input bit useExp, input logic [7:0] expData);
        int idx;
        bit hit;
        logic [7:0] exp;
        idx = int'(a) % DEPTH;
        hit = BUF_EN && rd && !wr && bufValid && (bufIdx == idx);
        @(negedge clk);
        readMem_en = rd; writeMem_en = wr; addr = a; wdata = d;
        #1;
        if (rd && wr) begin
            chk("errPulse", 32'(err), 1);
            chk("errNoStall", 32'(stall), 0);
            chk("errNoValid", 32'(rdata_valid), 0);
            @(negedge clk);
            readMem_en = 1'b0; writeMem_en = 1'b0;
            #1;
            chk("errOneCycle", 32'(err), 0);
            chk("errStaysIdle", 32'(stall), 0);
        end else if (!rd && !wr) begin
            chk("idleStall", 32'(stall), 0);
            chk("idleErr", 32'(err), 0);
            chk("idleValid", 32'(rdata_valid), 0);
            chk("rdataHold", 32'(rdata), 32'(lastRd));
        end else if (hit) begin
            exp = useExp ? expData : bufData;
            chk("hitStall", 32'(stall), 0);
            chk("hitValid", 32'(rdata_valid), 1);
            chk("hitData", 32'(rdata), 32'(exp));
            lastRd = exp;
        end else begin
            chk("reqStall", 32'(stall), 1);
            chk("reqValid", 32'(rdata_valid), 0);
            chk("reqErr", 32'(err), 0);
            for (int c = 0; c < WAIT_CYC; c++) begin
                @(negedge clk);
                driveIgnored(perturb);
                #1;
                chk("waitStall", 32'(stall), 1);
                chk("waitValid", 32'(rdata_valid), 0);
                chk("waitErr", 32'(err), 0);
            end
            @(negedge clk);
            driveIgnored(perturb);
            #1;
            chk("doneStall", 32'(stall), 0);
            chk("doneErr", 32'(err), 0);
            chk("doneValid", 32'(rdata_valid), 32'(rd));
            if (rd) begin
                exp = useExp ? expData : mem[idx];
                chk("loadData", 32'(rdata), 32'(exp));
                lastRd  = exp;
                bufData = mem[idx];
            end else begin
                mem[idx] = d;
                bufData  = d;
            end
            bufValid = 1'b1;
            bufIdx   = idx;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prevA;
        int kind;
        logic [7:0] a;

        tbl[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 1'b1, 8'h20, 8'h5A, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h20, 8'hFF, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h5A};
        tbl[5]  = '{1'b0, 1'b1, 8'h85, 8'h3C, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h3C};
        tbl[7]  = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 8'h50, 8'h66, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'h51, 8'h12, 8'h00};
        tbl[11] = '{1'b1, 1'b0, 8'h50, 8'h00, 8'h66};
        tbl[12] = '{1'b1, 1'b0, 8'h50, 8'h00, 8'h66};
        tbl[13] = '{1'b0, 1'b1, 8'h50, 8'h99, 8'h00};
        tbl[14] = '{1'b1, 1'b0, 8'h50, 8'h00, 8'h99};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rstStall", 32'(stall), 0);
        chk("rstValid", 32'(rdata_valid), 0);
        chk("rstErr", 32'(err), 0);
        chk("rstRdata", 32'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            runOp(1'b0, 1'b1, 8'(i), 8'($urandom), 1'b0, 1'b0, 8'h00);
        end

        for (int i = 0; i < 15; i++) begin
            runOp(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, tbl[i].rd && !tbl[i].wr, tbl[i].expRd);
        end

        // Address and data change while the store is waiting
        runOp(1'b0, 1'b1, 8'h31, 8'h22, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        readMem_en = 1'b0; writeMem_en = 1'b1; addr = 8'h30; wdata = 8'h11;
        #1;
        chk("midStall0", 32'(stall), 1);
        for (int c = 0; c < WAIT_CYC; c++) begin
            @(negedge clk);
            addr = 8'h31; wdata = 8'hFF;
            #1;
            chk("midStallW", 32'(stall), 1);
        end
        @(negedge clk);
        writeMem_en = 1'b0;
        #1;
        chk("midDoneStall", 32'(stall), 0);
        chk("midDoneValid", 32'(rdata_valid), 0);
        mem[8'h30] = 8'h11;
        bufValid = 1'b1; bufIdx = 8'h30; bufData = 8'h11;
        runOp(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 8'h11);
        runOp(1'b1, 1'b0, 8'h31, 8'h00, 1'b0, 1'b1, 8'h22);

        // Reset during the wait states of a store
        @(negedge clk);
        writeMem_en = 1'b1; addr = 8'h40; wdata = 8'h77;
        #1;
        chk("rstWrStall", 32'(stall), 1);
        @(negedge clk);
        writeMem_en = 1'b0;
        #1;
        chk("rstWrWait", 32'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abortStall", 32'(stall), 0);
        chk("abortValid", 32'(rdata_valid), 0);
        chk("abortErr", 32'(err), 0);
        chk("abortRdata", 32'(rdata), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bufValid = 1'b0;
        lastRd = 8'h00;
        runOp(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h00);

        // Random traffic with ignored enable/address noise during the access
        prevA = 8'h40;
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 2) == 0) ? prevA : 8'($urandom);
            if (kind == 0)      runOp(1'b1, 1'b1, a, 8'($urandom), 1'b1, 1'b0, 8'h00);
            else if (kind == 1) runOp(1'b0, 1'b0, a, 8'($urandom), 1'b1, 1'b0, 8'h00);
            else if (kind < 5)  runOp(1'b0, 1'b1, a, 8'($urandom), 1'b1, 1'b0, 8'h00);
            else                runOp(1'b1, 1'b0, a, 8'($urandom), 1'b1, 1'b0, 8'h00);
            prevA = a;
        end

        @(negedge clk);
        readMem_en = 1'b0; writeMem_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
